// File: rtl/dac_stream_ctrl_if.sv
// Producer-side frame handshake for dac_stream_ctrl: one stereo frame per
// accepted wr_valid/wr_ready cycle.
interface dac_stream_ctrl_if #(
   parameter int SW = 16
);
   logic                 wr_valid;
   logic                 wr_ready;
   logic signed [SW-1:0] wr_l;
   logic signed [SW-1:0] wr_r;

   modport master (output wr_valid, output wr_l, output wr_r, input wr_ready);
   modport slave  (input wr_valid, input wr_l, input wr_r, output wr_ready);
endinterface

// File: rtl/dac_stream_ctrl.sv
// Audio DAC stream controller: fractional rate generator producing oversample
// ticks, a stereo frame FIFO, and sample-boundary output registers.
module dac_stream_ctrl #(
   parameter int SW            = 16,
   parameter int DEPTH_LOG2    = 4,
   parameter int PHASE_W       = 9,
   parameter int CLK_HZ        = 50000000,
   parameter int UNDERRUN_ZERO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  snd_on,
   input  logic [15:0]           rate,
   input  logic                  err_clr,
   dac_stream_ctrl_if.slave      wr,
   output logic                  dac_clk,
   output logic [PHASE_W-1:0]    phase,
   output logic                  next_sample,
   output logic signed [SW-1:0]  snd_l,
   output logic signed [SW-1:0]  snd_r,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  underrun
);
   localparam logic [31:0]           CLK_C  = 32'(CLK_HZ);
   localparam logic [DEPTH_LOG2:0]   FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PHASE_W-1:0]    PH_MAX = '1;

   logic [31:0]            acc_q, acc_d;
   logic                   dac_clk_q, dac_clk_d;
   logic [PHASE_W-1:0]     phase_q, phase_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]    level_q, level_d;
   logic signed [SW-1:0]   snd_l_q, snd_l_d;
   logic signed [SW-1:0]   snd_r_q, snd_r_d;
   logic                   underrun_q, underrun_d;

   logic [31:0]            inc;
   logic [31:0]            sum;
   logic                   wr_ready;
   logic                   push;
   logic                   pop;
   logic                   starve;
   logic [2*SW-1:0]        head;

   logic [2*SW-1:0]        mem [1 << DEPTH_LOG2];

   assign wr_ready    = snd_on & (level_q != FULL);
   assign wr.wr_ready = wr_ready;
   assign dac_clk     = dac_clk_q & snd_on;
   assign next_sample = dac_clk & (phase_q == PH_MAX);
   assign push        = wr.wr_valid & wr_ready;
   assign pop         = next_sample & (level_q != '0);
   assign starve      = next_sample & (level_q == '0);
   assign head        = mem[rd_ptr_q];

   assign phase    = phase_q;
   assign snd_l    = snd_l_q;
   assign snd_r    = snd_r_q;
   assign level    = level_q;
   assign underrun = underrun_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {wr.wr_l, wr.wr_r};
      end
   end

   always_comb begin
      inc        = 32'(rate) << PHASE_W;
      sum        = acc_q + inc;
      acc_d      = acc_q;
      dac_clk_d  = 1'b0;
      phase_d    = phase_q + PHASE_W'(dac_clk);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      snd_l_d    = snd_l_q;
      snd_r_d    = snd_r_q;
      underrun_d = starve | (underrun_q & ~err_clr);

      // Saturated rate: tick every cycle and park acc so it cannot run away.
      if (inc >= CLK_C) begin
         dac_clk_d = 1'b1;
      end else if (sum >= CLK_C) begin
         acc_d     = sum - CLK_C;
         dac_clk_d = 1'b1;
      end else begin
         acc_d = sum;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         snd_l_d  = head[2*SW-1:SW];
         snd_r_d  = head[SW-1:0];
      end else if (starve && (UNDERRUN_ZERO != 0)) begin
         snd_l_d = '0;
         snd_r_d = '0;
      end
      level_d = level_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};

      if (!snd_on) begin
         acc_d     = '0;
         dac_clk_d = 1'b0;
         phase_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         snd_l_d   = '0;
         snd_r_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         dac_clk_q  <= 1'b0;
         phase_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         snd_l_q    <= '0;
         snd_r_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         dac_clk_q  <= dac_clk_d;
         phase_q    <= phase_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         snd_l_q    <= snd_l_d;
         snd_r_q    <= snd_r_d;
         underrun_q <= underrun_d;
      end
   end
endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Bench for dac_stream_ctrl: directed scenarios plus random traffic, each cycle
// compared against a queue-based reference model of the stream rules.
module tb_dac_stream_ctrl;
   localparam int SW     = 16;
   localparam int DL     = 2;
   localparam int PW     = 2;
   localparam int CLKHZ  = 1000;
   localparam int UZ     = 0;
   localparam int DEPTH  = 1 << DL;
   localparam int PMAX   = (1 << PW) - 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 snd_on = 1'b0;
   logic                 err_clr = 1'b0;
   logic [15:0]          rate = '0;
   logic                 dac_clk;
   logic [PW-1:0]        phase;
   logic                 next_sample;
   logic signed [SW-1:0] snd_l;
   logic signed [SW-1:0] snd_r;
   logic [DL:0]          level;
   logic                 underrun;

   dac_stream_ctrl_if #(.SW(SW)) wr_if ();

   dac_stream_ctrl #(
      .SW(SW), .DEPTH_LOG2(DL), .PHASE_W(PW), .CLK_HZ(CLKHZ), .UNDERRUN_ZERO(UZ)
   ) dut (
      .clk(clk), .rst_n(rst_n), .snd_on(snd_on), .rate(rate), .err_clr(err_clr),
      .wr(wr_if), .dac_clk(dac_clk), .phase(phase), .next_sample(next_sample),
      .snd_l(snd_l), .snd_r(snd_r), .level(level), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: tick accumulator in plain integers, FIFO as queues.
   int m_acc;
   bit m_tick;
   int m_phase;
   int m_q_l[$];
   int m_q_r[$];
   int m_l, m_r;
   bit m_under;
   bit s_clk, s_ns;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_tick = 0; m_phase = 0;
      m_q_l.delete(); m_q_r.delete();
      m_l = 0; m_r = 0; m_under = 0;
   endtask

   task automatic check_all();
      int e_clk, e_ns, e_rdy;
      e_clk = (snd_on && m_tick) ? 1 : 0;
      e_ns  = (e_clk == 1 && m_phase == PMAX) ? 1 : 0;
      e_rdy = (snd_on && m_q_l.size() < DEPTH) ? 1 : 0;
      check("dac_clk", 32'(dac_clk), e_clk);
      check("next_sample", 32'(next_sample), e_ns);
      check("phase", 32'(phase), m_phase);
      check("wr_ready", 32'(wr_if.wr_ready), e_rdy);
      check("level", 32'(level), m_q_l.size());
      check("snd_l", 32'(snd_l), m_l);
      check("snd_r", 32'(snd_r), m_r);
      check("underrun", 32'(underrun), 32'(m_under));
      s_clk = dac_clk;
      s_ns  = next_sample;
   endtask

   task automatic model_step();
      int inc, sum;
      bit ns, push, pop, starve;
      if (!snd_on) begin
         m_acc = 0; m_tick = 0; m_phase = 0;
         m_q_l.delete(); m_q_r.delete();
         m_l = 0; m_r = 0;
         if (err_clr) m_under = 0;
      end else begin
         ns     = m_tick && (m_phase == PMAX);
         push   = wr_if.wr_valid && (m_q_l.size() < DEPTH);
         pop    = ns && (m_q_l.size() > 0);
         starve = ns && (m_q_l.size() == 0);
         if (pop) begin
            m_l = m_q_l.pop_front();
            m_r = m_q_r.pop_front();
            $display("pop  l=%0d r=%0d", m_l, m_r);
         end else if (starve && UZ != 0) begin
            m_l = 0; m_r = 0;
         end
         if (push) begin
            m_q_l.push_back(int'($signed(wr_if.wr_l)));
            m_q_r.push_back(int'($signed(wr_if.wr_r)));
            $display("push l=%0d r=%0d level=%0d", $signed(wr_if.wr_l), $signed(wr_if.wr_r), m_q_l.size());
         end
         m_phase = (m_phase + int'(m_tick)) % (PMAX + 1);
         inc = int'(rate) * (1 << PW);
         if (inc >= CLKHZ) begin
            m_tick = 1;
         end else begin
            sum = m_acc + inc;
            if (sum >= CLKHZ) begin
               m_acc = sum - CLKHZ; m_tick = 1;
            end else begin
               m_acc = sum; m_tick = 0;
            end
         end
         m_under = starve ? 1'b1 : (err_clr ? 1'b0 : m_under);
      end
   endtask

   // Inputs are set just after a falling edge; check, advance model, move on.
   task automatic cyc();
      #1;
      check_all();
      model_step();
      @(negedge clk);
   endtask

   task automatic push_frame(input int l, input int r);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_l = 16'(l);
      wr_if.wr_r = 16'(r);
      cyc();
      wr_if.wr_valid = 1'b0;
   endtask

   initial begin
      int ticks, nss, last_t, last_ns, k;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_l = '0;
      wr_if.wr_r = '0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Rate 50: tick every 5 cycles, sample boundary every 20.
      snd_on = 1'b1; rate = 16'd50;
      ticks = 0; nss = 0; last_t = -1; last_ns = -1;
      for (int i = 0; i < 45; i++) begin
         cyc();
         if (s_clk) begin
            ticks++;
            if (last_t >= 0) check("tick_gap", i - last_t, 5);
            last_t = i;
         end
         if (s_ns) begin
            nss++;
            if (last_ns >= 0) check("ns_gap", i - last_ns, 20);
            last_ns = i;
         end
      end
      check("tick_cnt", ticks, 8);
      check("ns_cnt", nss, 2);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      cyc();

      // Fill the FIFO, drain it in order, then starve it.
      snd_on = 1'b0; cyc(); cyc();
      snd_on = 1'b1; rate = 16'd50;
      for (int i = 1; i <= 4; i++) push_frame(i, -i);
      #1;
      check("full_level", 32'(level), 4);
      check("full_ready", 32'(wr_if.wr_ready), 0);
      k = 0;
      for (int i = 0; i < 120 && k < 5; i++) begin
         cyc();
         if (s_ns) begin
            #1;
            if (k < 4) begin
               check("pop_l", 32'(snd_l), k + 1);
               check("pop_r", 32'(snd_r), -(k + 1));
            end else begin
               check("hold_l", 32'(snd_l), 4);
               check("hold_r", 32'(snd_r), -4);
               check("under_set", 32'(underrun), 1);
            end
            k++;
         end
      end
      check("ns_seen", k, 5);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      #1;
      check("under_clr", 32'(underrun), 0);

      // Level 2, push only on sample boundaries: level must not move.
      snd_on = 1'b0; cyc();
      snd_on = 1'b1; rate = 16'd0;
      push_frame(10, -10);
      push_frame(11, -11);
      rate = 16'd300; cyc();
      for (int i = 0; i < 16; i++) begin
         wr_if.wr_valid = (m_tick && m_phase == PMAX);
         wr_if.wr_l = 16'(20 + i);
         wr_if.wr_r = 16'(-20 - i);
         cyc();
         #1;
         check("lvl_hold", 32'(level), 2);
      end
      wr_if.wr_valid = 1'b0;

      // Rate 0 never ticks; saturated rate ticks every cycle.
      rate = 16'd0; cyc();
      ticks = 0;
      for (int i = 0; i < 20; i++) begin cyc(); ticks += int'(s_clk); end
      check("rate0_ticks", ticks, 0);
      rate = 16'd300; cyc();
      ticks = 0;
      for (int i = 0; i < 20; i++) begin cyc(); ticks += int'(s_clk); end
      check("rate300_ticks", ticks, 20);

      // Asynchronous reset mid-stream with three frames buffered.
      snd_on = 1'b0; cyc();
      snd_on = 1'b1; rate = 16'd0;
      for (int i = 0; i < 4; i++) push_frame(30 + i, -30 - i);
      rate = 16'd300;
      for (int i = 0; i < 20 && m_q_l.size() != 3; i++) cyc();
      rate = 16'd0;
      #1;
      check("pre_rst_level", 32'(level), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_level", 32'(level), 0);
      check("rst_snd_l", 32'(snd_l), 0);
      check("rst_snd_r", 32'(snd_r), 0);
      check("rst_dac_clk", 32'(dac_clk), 0);
      check("rst_phase", 32'(phase), 0);
      check("rst_underrun", 32'(underrun), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc();

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 5))
               0: rate = 16'd0;
               1: rate = 16'd50;
               2: rate = 16'd100;
               3: rate = 16'd250;
               4: rate = 16'd300;
               default: rate = 16'($urandom_range(0, 400));
            endcase
         end
         if ($urandom_range(0, 199) == 0) snd_on = ~snd_on;
         else if (!snd_on && $urandom_range(0, 9) == 0) snd_on = 1'b1;
         wr_if.wr_valid = 1'($urandom_range(0, 1));
         wr_if.wr_l = 16'($urandom);
         wr_if.wr_r = 16'($urandom);
         err_clr = ($urandom_range(0, 19) == 0);
         cyc();
      end
      wr_if.wr_valid = 1'b0;
      err_clr = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dac_stream_ctrl.md
DAC_STREAM_CTRL -- requirements
Module: dac_stream_ctrl

Interface
REQ-001 SHALL have parameter SW, default 16, DAC sample width in bits per channel.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, giving a sample FIFO depth of 2^DEPTH_LOG2 stereo frames.
REQ-003 SHALL have parameter PHASE_W, default 9, giving an oversample of 2^PHASE_W dac_clk ticks per sample.
REQ-004 SHALL have parameter CLK_HZ, default 50000000, the clk frequency in Hz.
REQ-005 SHALL have parameter UNDERRUN_ZERO, default 0: 0 holds the last sample on underrun, 1 outputs zero.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  system clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 snd_on  in  1  stream enable.
REQ-010 rate  in  16  sample rate in Hz.
REQ-011 wr_valid  in  1  producer presents a frame.
REQ-012 wr_l, wr_r  in  SW each  signed left and right samples.
REQ-013 wr_ready  out  1  FIFO can accept a frame.
REQ-014 err_clr  in  1  clears the underrun flag.
REQ-015 dac_clk  out  1  one-cycle oversample tick.
REQ-016 phase  out  PHASE_W  oversample phase counter.
REQ-017 next_sample  out  1  sample boundary strobe.
REQ-018 snd_l, snd_r  out  SW each  signed current output samples.
REQ-019 level  out  DEPTH_LOG2+1  FIFO occupancy.
REQ-020 underrun  out  1  sticky underrun flag.

Function
REQ-021 Rate generator SHALL be a 32-bit accumulator: inc = rate * 2^PHASE_W, and sum = acc + inc each cycle.
REQ-022 Rate generator: if sum >= CLK_HZ, acc SHALL load sum - CLK_HZ and dac_clk SHALL be 1 in the next cycle; otherwise acc SHALL load sum and dac_clk SHALL be 0.
REQ-023 If inc >= CLK_HZ, dac_clk SHALL be 1 every cycle.
REQ-024 If rate == 0, dac_clk SHALL never assert.
REQ-025 A rate change SHALL take effect on the next cycle without clearing acc or phase.
REQ-026 phase SHALL increment by 1 modulo 2^PHASE_W in each cycle where dac_clk == 1.
REQ-027 next_sample SHALL equal dac_clk AND (phase == 2^PHASE_W-1), combinationally.
REQ-028 Push SHALL occur when wr_valid && wr_ready; wr_ready SHALL equal (level != 2^DEPTH_LOG2).
REQ-029 Pop SHALL occur on a next_sample cycle when level != 0; snd_l and snd_r SHALL take the head frame one cycle later.
REQ-030 Push and pop in the same cycle SHALL both complete, leaving level unchanged.
REQ-031 A push into a full FIFO SHALL be impossible, because wr_ready is low.
REQ-032 Pointers SHALL wrap modulo the FIFO depth.
REQ-033 On a next_sample cycle with level == 0: outputs SHALL hold their value (UNDERRUN_ZERO=0) or load 0 (UNDERRUN_ZERO=1), and underrun SHALL set.
REQ-034 err_clr SHALL clear underrun; a set in the same cycle SHALL win.
REQ-035 While snd_on == 0, acc, phase, FIFO pointers and snd_l/snd_r SHALL be held at 0.
REQ-036 While snd_on == 0, dac_clk and next_sample SHALL be 0 and wr_ready SHALL be 0.
REQ-037 On a rising edge of snd_on, operation SHALL start from the empty state on the next cycle.
REQ-038 Data SHALL pass through the FIFO unmodified, in FIFO order, with L/R pairing preserved.

Reset
REQ-039 rst_n low SHALL immediately clear acc, phase, FIFO pointers, level, snd_l, snd_r, dac_clk and underrun to 0.
REQ-040 Reset asserted mid-stream SHALL discard all buffered frames.
REQ-041 After rst_n rises, the first push SHALL be accepted no earlier than the first clk edge.

Verification (CLK_HZ=1000, PHASE_W=2, DEPTH_LOG2=2)
REQ-042 Bench SHALL cover: snd_on=1, rate=50 -> dac_clk every 5 cycles exactly, next_sample every 20 cycles, phase sequence 0,1,2,3.
REQ-043 Bench SHALL cover: push 4 frames (L=1..4, R=-1..-4) with no pop -> level=4 and wr_ready=0; successive next_sample strobes -> snd_l = 1,2,3,4 and snd_r = -1,-2,-3,-4.
REQ-044 Bench SHALL cover: fifth next_sample with an empty FIFO -> underrun=1, outputs hold 4/-4 (UNDERRUN_ZERO=0) or go to 0/0 (UNDERRUN_ZERO=1); err_clr pulse -> underrun=0.
REQ-045 Bench SHALL cover: level=2 with push and pop in the same cycle -> level stays 2 and frame order is intact.
REQ-046 Bench SHALL cover: rate=300 (inc=1200 >= 1000) -> dac_clk high every cycle; rate=0 -> no ticks.
REQ-047 Bench SHALL cover: rst_n pulsed low asynchronously with level=3 -> all outputs 0 before the next clk edge and level=0.
